// File: rtl/uart_mailbox_bridge.sv
// Serial side of the RAM UART mailbox: 8N1 RX into mailbox word 2, TX from mailbox word 3.
// Both directions use a bit-8 toggle handshake, so software never has to clear a flag after reading.
module uart_mailbox_bridge #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned BAUD_DIV  = 434
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_in,
   output logic                 tx_out,
   input  logic [BIT_WIDTH-1:0] READ_UART,
   output logic [BIT_WIDTH-1:0] WRITE_UART,
   output logic                 W_UART,
   output logic                 tx_busy,
   output logic                 rx_frame_err
);

   localparam int unsigned   CW        = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   logic                 r_rx_meta, r_rx_s;
   rx_state_t            r_rx_state;
   logic [CW-1:0]        r_rx_cnt;
   logic [2:0]           r_rx_bit;
   logic [7:0]           r_rx_shift;
   logic                 r_rx_tog;
   logic [BIT_WIDTH-1:0] r_write;
   logic                 r_w;
   logic                 r_frame_err;

   tx_state_t            r_tx_state;
   logic [CW-1:0]        r_tx_cnt;
   logic [2:0]           r_tx_bit;
   logic [7:0]           r_tx_shift;
   logic                 r_tx_ack;
   logic                 r_tx_busy;
   logic                 r_tx_out;

   // Mailbox bits above the request toggle carry nothing for the transmitter.
   logic w_unused_read;
   assign w_unused_read = ^READ_UART[BIT_WIDTH-1:8];

   assign tx_out       = r_tx_out;
   assign WRITE_UART   = r_write;
   assign W_UART       = r_w;
   assign tx_busy      = r_tx_busy;
   assign rx_frame_err = r_frame_err;

   // Resets to the idle line level so reset release cannot fake a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= rx_in;
         r_rx_s    <= r_rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_state  <= RX_IDLE;
         r_rx_cnt    <= '0;
         r_rx_bit    <= '0;
         r_rx_shift  <= '0;
         r_rx_tog    <= 1'b0;
         r_write     <= '0;
         r_w         <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_w         <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               r_rx_cnt <= '0;
               if (!r_rx_s) r_rx_state <= RX_START;
            end
            // Half-bit wait re-checks the start bit and centres later samples.
            RX_START: begin
               if (r_rx_cnt == HALF_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_bit   <= '0;
                  r_rx_state <= r_rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + CW'(1);
               end
            end
            RX_DATA: begin
               if (r_rx_cnt == BAUD_LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_shift <= {r_rx_s, r_rx_shift[7:1]};
                  r_rx_bit   <= r_rx_bit + 3'd1;
                  if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
               end else begin
                  r_rx_cnt <= r_rx_cnt + CW'(1);
               end
            end
            RX_STOP: begin
               if (r_rx_cnt == BAUD_LAST) begin
                  r_rx_cnt <= '0;
                  if (r_rx_s) begin
                     r_rx_tog   <= ~r_rx_tog;
                     r_write    <= BIT_WIDTH'({~r_rx_tog, r_rx_shift});
                     r_w        <= 1'b1;
                     r_rx_state <= RX_IDLE;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_rx_state  <= RX_BREAK;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt + CW'(1);
               end
            end
            RX_BREAK: begin
               if (r_rx_s) r_rx_state <= RX_IDLE;
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   // A frame starts only when the posted toggle differs from the last one acknowledged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_ack   <= 1'b0;
         r_tx_busy  <= 1'b0;
         r_tx_out   <= 1'b1;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               r_tx_cnt <= '0;
               r_tx_bit <= '0;
               if (READ_UART[8] != r_tx_ack) begin
                  r_tx_shift <= READ_UART[7:0];
                  r_tx_ack   <= READ_UART[8];
                  r_tx_busy  <= 1'b1;
                  r_tx_out   <= 1'b0;
                  r_tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (r_tx_cnt == BAUD_LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_out   <= r_tx_shift[0];
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_tx_state <= TX_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + CW'(1);
               end
            end
            TX_DATA: begin
               if (r_tx_cnt == BAUD_LAST) begin
                  r_tx_cnt <= '0;
                  r_tx_bit <= r_tx_bit + 3'd1;
                  if (r_tx_bit == 3'd7) begin
                     r_tx_out   <= 1'b1;
                     r_tx_state <= TX_STOP;
                  end else begin
                     r_tx_out   <= r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + CW'(1);
               end
            end
            TX_STOP: begin
               if (r_tx_cnt == BAUD_LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_busy  <= 1'b0;
                  r_tx_state <= TX_IDLE;
               end else begin
                  r_tx_cnt <= r_tx_cnt + CW'(1);
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mailbox_bridge.sv
// Self-checking bench for uart_mailbox_bridge: RX vector table, random RX/TX against a
// toggle/byte reference model, and directed reset, glitch, break and loopback sequences.
module tb_uart_mailbox_bridge;

   localparam int unsigned BW = 32;
   localparam int unsigned BD = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_drv;
   logic          loop_en;
   logic          rx_line;
   logic [BW-1:0] read_uart;
   logic          tx_out;
   logic [BW-1:0] write_uart;
   logic          w_uart;
   logic          tx_busy;
   logic          rx_frame_err;

   assign rx_line = loop_en ? tx_out : rx_drv;

   uart_mailbox_bridge #(.BIT_WIDTH(BW), .BAUD_DIV(BD)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_in        (rx_line),
      .tx_out       (tx_out),
      .READ_UART    (read_uart),
      .WRITE_UART   (write_uart),
      .W_UART       (w_uart),
      .tx_busy      (tx_busy),
      .rx_frame_err (rx_frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic        stopb;
      logic [31:0] exp_word;
      int          exp_w;
      int          exp_e;
   } rx_vec_t;

   rx_vec_t     tbl[6];
   int          n_vec = 0;
   int          n_err = 0;
   int          w_cnt = 0, w_wide = 0, err_cnt = 0, err_wide = 0, tx_low = 0;
   logic        w_prev = 1'b0, e_prev = 1'b0;
   logic [31:0] wq[$];
   int          w0, e0, l0;
   logic        m_tog;
   logic        req;
   logic [7:0]  b;

   // Observes strobes, pulse widths and line activity every cycle.
   always @(negedge clk) begin
      if (w_uart === 1'b1) begin
         wq.push_back(write_uart);
         w_cnt++;
         if (w_prev) w_wide++;
      end
      if (rx_frame_err === 1'b1) begin
         err_cnt++;
         if (e_prev) err_wide++;
      end
      if (tx_out === 1'b0) tx_low++;
      w_prev = w_uart;
      e_prev = rx_frame_err;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d miscompares so far", n_err);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] d, input logic stopb);
      rx_drv = 1'b0;
      tick(BD);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         tick(BD);
      end
      rx_drv = stopb;
      tick(BD);
   endtask

   // Checks one whole frame cycle by cycle: start, 8 data bits LSB first, stop.
   task automatic capture_tx(input logic [7:0] d, input string name);
      logic [9:0] frame;
      int         waited;
      int         bad;
      int         busy_cnt;
      frame    = {1'b1, d, 1'b0};
      waited   = 0;
      bad      = 0;
      busy_cnt = 0;
      while (tx_out !== 1'b0 && waited < 200) begin
         tick(1);
         waited++;
      end
      check({name, "_start"}, 32'(tx_out), 32'd0);
      if (tx_out === 1'b0) begin
         for (int i = 0; i < 80; i++) begin
            if (tx_out !== frame[i/8]) bad++;
            if (tx_busy === 1'b1) busy_cnt++;
            tick(1);
         end
         check({name, "_bits"}, 32'(bad), 32'd0);
         check({name, "_busy_len"}, 32'(busy_cnt), 32'd80);
         check({name, "_busy_end"}, 32'(tx_busy), 32'd0);
      end
   endtask

   task automatic wait_write(input int base, input logic [31:0] exp, input string name);
      int t;
      t = 0;
      while (w_cnt == base && t < 400) begin
         tick(1);
         t++;
      end
      tick(1);
      check({name, "_cnt"}, 32'(w_cnt - base), 32'd1);
      check({name, "_word"}, write_uart, exp);
   endtask

   initial begin
      reset     = 1'b1;
      rx_drv    = 1'b1;
      loop_en   = 1'b0;
      read_uart = '0;
      m_tog     = 1'b0;
      req       = 1'b0;
      b         = '0;

      tbl[0] = '{8'h5A, 1'b1, 32'h0000015A, 1, 0};
      tbl[1] = '{8'hC3, 1'b1, 32'h000000C3, 1, 0};
      tbl[2] = '{8'h00, 1'b0, 32'h000000C3, 0, 1};
      tbl[3] = '{8'h11, 1'b1, 32'h00000111, 1, 0};
      tbl[4] = '{8'hFF, 1'b1, 32'h000000FF, 1, 0};
      tbl[5] = '{8'h80, 1'b1, 32'h00000180, 1, 0};

      tick(3);
      check("rst_tx_out", 32'(tx_out), 32'd1);
      check("rst_w_uart", 32'(w_uart), 32'd0);
      check("rst_write", write_uart, 32'd0);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_ferr", 32'(rx_frame_err), 32'd0);
      reset = 1'b0;

      // Quiet line for 1000 cycles.
      l0 = tx_low;
      w0 = w_cnt;
      tick(1000);
      check("idle_tx_low", 32'(tx_low - l0), 32'd0);
      check("idle_writes", 32'(w_cnt - w0), 32'd0);
      check("idle_word", write_uart, 32'd0);

      // Held request after reset transmits exactly once.
      read_uart = 32'h000001A5;
      capture_tx(8'hA5, "tx_a5");
      l0 = tx_low;
      tick(200);
      check("tx_a5_single", 32'(tx_low - l0), 32'd0);

      foreach (tbl[i]) begin
         w0 = w_cnt;
         e0 = err_cnt;
         wq.delete();
         send_rx(tbl[i].data, tbl[i].stopb);
         if (!tbl[i].stopb) begin
            tick(30);
            rx_drv = 1'b1;
         end
         tick(12);
         check($sformatf("rx%0d_word", i), write_uart, tbl[i].exp_word);
         check($sformatf("rx%0d_writes", i), 32'(w_cnt - w0), 32'(tbl[i].exp_w));
         check($sformatf("rx%0d_errs", i), 32'(err_cnt - e0), 32'(tbl[i].exp_e));
         if (wq.size() > 0) check($sformatf("rx%0d_strobe_word", i), wq[0], tbl[i].exp_word);
         if (tbl[i].stopb) m_tog = ~m_tog;
      end
      check("rx_w_pulse_width", 32'(w_wide), 32'd0);
      check("rx_err_pulse_width", 32'(err_wide), 32'd0);

      for (int k = 0; k < 8; k++) begin
         b     = 8'($urandom_range(0, 255));
         m_tog = ~m_tog;
         w0    = w_cnt;
         send_rx(b, 1'b1);
         tick(12);
         check($sformatf("rxr%0d_word", k), write_uart, {23'd0, m_tog, b});
         check($sformatf("rxr%0d_writes", k), 32'(w_cnt - w0), 32'd1);
      end

      // Two-cycle start glitch is rejected silently.
      w0     = w_cnt;
      e0     = err_cnt;
      rx_drv = 1'b0;
      tick(2);
      rx_drv = 1'b1;
      tick(40);
      check("glitch_writes", 32'(w_cnt - w0), 32'd0);
      check("glitch_errs", 32'(err_cnt - e0), 32'd0);

      // Reset in the middle of a transmit frame.
      read_uart = 32'h00000033;
      tick(30);
      check("midtx_busy", 32'(tx_busy), 32'd1);
      reset = 1'b1;
      #1;
      check("midtx_rst_tx_out", 32'(tx_out), 32'd1);
      check("midtx_rst_busy", 32'(tx_busy), 32'd0);
      check("midtx_rst_write", write_uart, 32'd0);
      tick(2);
      reset = 1'b0;
      m_tog = 1'b0;
      l0    = tx_low;
      tick(100);
      check("post_rst_no_frame", 32'(tx_low - l0), 32'd0);
      read_uart = 32'h0000013C;
      capture_tx(8'h3C, "tx_3c");

      req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b         = 8'($urandom_range(0, 255));
         req       = ~req;
         read_uart = {23'd0, req, b};
         capture_tx(b, $sformatf("txr%0d", k));
      end

      // Data byte change alone must not start a frame.
      read_uart = {23'd0, req, ~b};
      l0        = tx_low;
      tick(150);
      check("tx_data_only_change", 32'(tx_low - l0), 32'd0);

      // Simultaneous receive and transmit.
      w0 = w_cnt;
      fork
         send_rx(8'h6E, 1'b1);
         begin
            req       = ~req;
            read_uart = {23'd0, req, 8'h91};
            capture_tx(8'h91, "conc_tx");
         end
      join
      m_tog = ~m_tog;
      tick(12);
      check("conc_rx_word", write_uart, {23'd0, m_tog, 8'h6E});
      check("conc_rx_writes", 32'(w_cnt - w0), 32'd1);

      // Loopback round trip from a clean reset.
      reset     = 1'b1;
      read_uart = '0;
      loop_en   = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(5);
      w0        = w_cnt;
      read_uart = 32'h00000100;
      wait_write(w0, 32'h00000100, "loop_100");
      w0        = w_cnt;
      read_uart = 32'h000000FF;
      wait_write(w0, 32'h000000FF, "loop_0ff");
      tick(20);
      w0        = w_cnt;
      read_uart = 32'h000001AA;
      tick(20);
      read_uart = 32'h000000AA;
      tick(10);
      read_uart = 32'h000001AA;
      tick(300);
      check("loop_dbl_toggle_writes", 32'(w_cnt - w0), 32'd1);
      check("loop_dbl_toggle_word", write_uart, 32'h000001AA);
      check("final_w_pulse_width", 32'(w_wide), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_mailbox_bridge.md
Name: uart_mailbox_bridge

Overview:
- Serial-side counterpart of the RAM UART mailbox.
- Receives 8N1 bytes on `rx_in` and writes them into mailbox word 0x10010008 (RAM word 2) through the `WRITE_UART`/`W_UART` port.
- Reads mailbox word 0x1001000C (RAM word 3) through `READ_UART` and transmits the byte the CPU posts there on `tx_out`.
- Both directions use a bit-8 toggle handshake, so software never needs a clear-after-read.

Parameters:
- BIT_WIDTH, 32: mailbox word width; must be ≥ 9.
- BAUD_DIV, 434: clk cycles per serial bit (50 MHz / 115200); must be ≥ 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_in  input  1  serial receive line; idle high; asynchronous to clk.
- tx_out  output  1  serial transmit line; idle high.
- READ_UART  input  BIT_WIDTH  current contents of RAM word 3 (TX mailbox).
  - [7:0] data byte.
  - [8] request toggle.
- WRITE_UART  output  BIT_WIDTH  data for RAM word 2 (RX mailbox).
- W_UART  output  1  one-cycle write strobe for WRITE_UART into RAM word 2.
- tx_busy  output  1  high while a frame is being transmitted.
- rx_frame_err  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset values:
  - tx_out = 1, W_UART = 0, WRITE_UART = 0, tx_busy = 0, rx_frame_err = 0.
  - rx_tog = 0, tx_ack = 0.
  - Both FSMs go to IDLE; baud and bit counters clear.
  - Reset asserted mid-frame aborts immediately. A partial byte is never written; tx_out returns high.
- RX synchroniser:
  - rx_in passes through a 2-flop synchroniser.
  - Only the synchronised signal (rx_s) is used afterwards.
- RX FSM:
  - IDLE: rx_s = 0 → START, baud counter cleared.
  - START: wait BAUD_DIV/2 cycles (integer divide), then sample.
    - Sample 0 → DATA, bit index 0.
    - Sample 1 (glitch) → IDLE; no write, no error.
  - DATA: sample every BAUD_DIV cycles, LSB first, 8 samples → STOP.
  - STOP: sample after BAUD_DIV cycles.
    - Sample 1:
      - rx_tog toggles.
      - WRITE_UART ← {zeros[BIT_WIDTH-1:9], new rx_tog, byte}.
      - W_UART = 1 for exactly the same single cycle.
      - → IDLE.
    - Sample 0:
      - rx_frame_err pulses one cycle; no write; rx_tog unchanged.
      - → BREAK.
  - BREAK: stay until rx_s = 1, then → IDLE.
  - WRITE_UART holds its last value between writes.
  - Overrun is not detected. A byte not consumed by software before the next write is overwritten; software detects new data by rx_tog changing.
- TX FSM:
  - IDLE, READ_UART[8] ≠ tx_ack:
    - Latch READ_UART[7:0] into the shift register.
    - tx_ack ← READ_UART[8].
    - tx_busy ← 1.
    - → START on the next cycle.
  - IDLE, READ_UART[8] = tx_ack: no frame starts.
  - START: tx_out = 0 for BAUD_DIV cycles.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each.
  - STOP: tx_out = 1 for BAUD_DIV cycles, then → IDLE.
    - tx_busy drops in the same cycle as the IDLE entry.
  - tx_out is registered, so it has no glitches.
  - The frame length is exactly 10·BAUD_DIV cycles, start-bit edge to IDLE entry.
  - READ_UART changes during a frame are ignored.
    - On return to IDLE, bit 8 is compared against tx_ack again.
    - Two toggles during one frame cancel, so nothing is sent.
    - Back-to-back requests give frames with no idle gap beyond one cycle.
  - A change of READ_UART[7:0] alone, with bit 8 unchanged, never starts a frame.
- Concurrency:
  - RX and TX are fully independent; simultaneous activity is legal.
  - Loopback (tx_out wired to rx_in) must round-trip bytes.
- Arithmetic:
  - Baud counter width is $clog2(BAUD_DIV) bits and wraps at BAUD_DIV-1.
  - Bit counter is 3 bits.

Test Plan:
- Reset, then idle with BAUD_DIV = 8 → tx_out = 1, W_UART never asserted, WRITE_UART = 0 for 1000 cycles.
- Drive RX frame 0x5A, then 0xC3 → first W_UART pulse is 1 cycle wide with WRITE_UART = 0x0000015A; second gives 0x000000C3 (toggle back to 0).
- Hold READ_UART = 0x000001A5 after reset → tx_out carries 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; tx_busy is high for 80 cycles; only one frame is sent.
- RX frame with stop bit 0, line held low 30 cycles, then a valid 0x11 frame → rx_frame_err is a single pulse with no W_UART; the 0x11 frame then writes 0x00000111.
- RX start glitch of 2 cycles low → no write and no error. Then assert reset mid-TX frame → tx_out = 1 immediately; after release, a new toggle sends a complete frame.
- Loopback, toggling READ_UART to 0x100, then 0x0FF, after each frame completes → WRITE_UART receives 0x00000100, then 0x000000FF.
  - Toggling twice during busy produces no extra frame.
